// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier.
// Drives an external arithmetic_unit for one partial-product step per clock.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     au_a,
    output logic [WIDTH-1:0]     au_b,
    output logic                 au_s1,
    output logic                 au_s0,
    output logic                 au_cin,
    input  logic [WIDTH-1:0]     au_g,
    input  logic                 au_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     m;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   p_next;
    logic                 last;

    // Carry-out becomes the new MSB, so the shifted 2W result stays exact.
    assign p_next = {au_cout, au_g, p[WIDTH-1:1]};
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Control FSM with registered handshake outputs and the product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            m       <= '0;
            p       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= multiplicand;
                        p     <= {{WIDTH{1'b0}}, multiplier};
                        cnt   <= '0;
                        state <= CALC;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    p   <= p_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= p_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Adder controls: add M only while calculating and the current Q bit is set.
    always_comb begin
        au_a   = p[2*WIDTH-1:WIDTH];
        au_b   = m;
        au_s1  = 1'b0;
        au_cin = 1'b0;
        au_s0  = 1'b0;
        if (state == CALC) begin
            au_s0 = p[0];
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier with a behavioural arithmetic_unit.
// Expected products are queued at stimulus time and popped on done.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   au_a;
    logic [W-1:0]   au_b;
    logic           au_s1;
    logic           au_s0;
    logic           au_cin;
    logic [W-1:0]   au_g;
    logic           au_cout;

    logic [W:0]     au_sum;
    logic [2*W-1:0] sb[$];

    int tests;
    int fails;

    seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .ready(ready),
        .busy(busy),
        .done(done),
        .product(product),
        .au_a(au_a),
        .au_b(au_b),
        .au_s1(au_s1),
        .au_s0(au_s0),
        .au_cin(au_cin),
        .au_g(au_g),
        .au_cout(au_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic unit: S1S0=01 adds A+B+Cin, anything else transfers A.
    always_comb begin
        if (!au_s1 && au_s0)
            au_sum = {1'b0, au_a} + {1'b0, au_b} + {{W{1'b0}}, au_cin};
        else
            au_sum = {1'b0, au_a};
        au_g    = au_sum[W-1:0];
        au_cout = au_sum[W];
    end

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int poke_at, input string nm,
                           output bit cout_seen, output bit s0_seen);
        int  busy_cnt;
        bit  got;
        bit  s1_seen;
        logic [2*W-1:0] exp;
        cout_seen = 0;
        s0_seen   = 0;
        s1_seen   = 0;
        busy_cnt  = 0;
        got       = 0;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_start got %b exp 1", nm, ready);
        end
        sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (busy) begin
                busy_cnt++;
                if (au_cout) cout_seen = 1;
                if (au_s0) s0_seen = 1;
                if (au_s1) s1_seen = 1;
                if (busy_cnt == poke_at) begin
                    start        = 1'b1;
                    multiplicand = $urandom;
                    multiplier   = $urandom;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                got = 1;
                exp = sb.pop_front();
                tests++;
                if (product !== exp) begin
                    fails++;
                    $display("FAIL %s product got %h exp %h", nm, product, exp);
                end
                tests++;
                if (busy !== 1'b0 || ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_flags busy %b ready %b exp 0 0",
                             nm, busy, ready);
                end
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout got no done exp done", nm);
            return;
        end
        tests++;
        if (busy_cnt != W) begin
            fails++;
            $display("FAIL %s calc_cycles got %0d exp %0d", nm, busy_cnt, W);
        end
        tests++;
        if (s1_seen) begin
            fails++;
            $display("FAIL %s au_s1 got 1 exp 0", nm);
        end
        exp = product;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || ready !== 1'b1 || product !== exp) begin
            fails++;
            $display("FAIL %s after_done done %b ready %b prod %h exp 0 1 %h",
                     nm, done, ready, product, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '1;
        multiplier = '1;
        repeat (2) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got r%b b%b d%b exp 1 0 0",
                     ready, busy, done);
        end
        tests++;
        if (product !== '0) begin
            fails++;
            $display("FAIL reset_product got %h exp 0", product);
        end
        tests++;
        if ({au_a, au_b, au_s1, au_s0, au_cin} !== '0) begin
            fails++;
            $display("FAIL reset_au got %h %h %b%b%b exp 0",
                     au_a, au_b, au_s1, au_s0, au_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit c, s;
        run_mul(32'h10, 32'h5, 0, "basic", c, s);
    endtask

    task automatic test_max();
        bit c, s;
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "max", c, s);
        tests++;
        if (!c) begin
            fails++;
            $display("FAIL max_cout got 0 exp 1");
        end
    endtask

    task automatic test_zero();
        bit c, s;
        run_mul(32'h12345678, 32'h0, 0, "zero_q", c, s);
        tests++;
        if (s) begin
            fails++;
            $display("FAIL zero_q_s0 got 1 exp 0");
        end
    endtask

    task automatic test_ignore_start();
        bit c, s;
        run_mul(32'd7, 32'd6, 5, "ignore", c, s);
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL ignore_idle busy %b done %b exp 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit c, s;
        bit seen_done;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready got %b exp 1", ready);
        end
        sb.push_back(64'hDEAD);
        multiplicand = 32'hABCDEF01;
        multiplier   = 32'h12345;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy got %b exp 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            product !== '0) begin
            fails++;
            $display("FAIL abort_state r%b b%b d%b p%h exp 1 0 0 0",
                     ready, busy, done, product);
        end
        tests++;
        if ({au_a, au_b, au_s0} !== '0) begin
            fails++;
            $display("FAIL abort_au got %h %h %b exp 0", au_a, au_b, au_s0);
        end
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        tests++;
        if (seen_done) begin
            fails++;
            $display("FAIL abort_done got 1 exp 0");
        end
        run_mul(32'd3, 32'd3, 0, "after_abort", c, s);
    endtask

    task automatic test_back_to_back();
        bit c, s;
        logic [W-1:0] va[6];
        logic [W-1:0] vb[6];
        va[0] = 32'h1;        vb[0] = 32'hFFFFFFFF;
        va[1] = 32'h80000000; vb[1] = 32'h80000000;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'h1;
        for (int i = 3; i < 6; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            run_mul(va[i], vb[i], 0, "b2b", c, s);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
